auto_nav_ctrl: RTL and testbench

- Parametrised autonomous maze-navigation controller for the car. It owns the drive state register, unlike the previous combinational next-state logic.
- Debounces the four wall detectors and applies a selectable left-hand or right-hand wall-following rule. Supports dead-end U-turns with beacon place/remove pulses.
- Dwell times are configurable in ticks from an internal prescaler. It sits between the detector inputs and the motor/mode mux, active when the top level asserts enable in auto mode.

---
 rtl/auto_nav_pkg.sv | 33 +++
 rtl/auto_nav_ctrl_debounce.sv | 43 ++++
 rtl/auto_nav_ctrl.sv | 152 +++++++++++++++
 tb/tb_auto_nav_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/auto_nav_pkg.sv
// Shared encodings and the wall-following decision rule for the maze-navigation controller.
package auto_nav_pkg;

    localparam logic [1:0] ST_WAITING = 2'b00;
    localparam logic [1:0] ST_MOVING  = 2'b01;
    localparam logic [1:0] ST_TURNING = 2'b10;
    localparam logic [1:0] ST_COOLING = 2'b11;

    localparam logic [3:0] MV_STOP    = 4'b0000;
    localparam logic [3:0] MV_FORWARD = 4'b0001;
    localparam logic [3:0] MV_LEFT    = 4'b0100;
    localparam logic [3:0] MV_RIGHT   = 4'b1000;

    typedef enum logic [1:0] {DEC_FWD, DEC_LEFT, DEC_RIGHT, DEC_DEAD} decision_t;

    // det = {front, left, right, back}; a 0 bit means that side is open.
    function automatic decision_t nav_decide(input logic [3:0] det, input logic hand);
        decision_t dec;
        if (!hand) begin
            if (!det[1])      dec = DEC_RIGHT;
            else if (!det[3]) dec = DEC_FWD;
            else if (!det[2]) dec = DEC_LEFT;
            else              dec = DEC_DEAD;
        end else begin
            if (!det[2])      dec = DEC_LEFT;
            else if (!det[3]) dec = DEC_FWD;
            else if (!det[1]) dec = DEC_RIGHT;
            else              dec = DEC_DEAD;
        end
        return dec;
    endfunction

endpackage

// File: rtl/auto_nav_ctrl_debounce.sv
// Wall-detector filter: the raw 4-bit value is adopted only after DEB_LEN identical samples.
module det_debounce #(
    parameter int DEB_LEN = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_raw,
    output logic [3:0] o_det_f
);

    localparam int CW = $clog2(DEB_LEN + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEB_LEN);

    logic [3:0]    r_prev;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_det_f;
    logic [CW-1:0] w_cnt_next;

    // Count of consecutive samples equal to the current one, including it.
    always_comb begin
        w_cnt_next = r_cnt;
        if (i_raw != r_prev)
            w_cnt_next = CW'(1);
        else if (r_cnt != CNT_FULL)
            w_cnt_next = r_cnt + 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prev  <= 4'b1111;
            r_cnt   <= '0;
            r_det_f <= 4'b1111;
        end else begin
            r_prev <= i_raw;
            r_cnt  <= w_cnt_next;
            if (w_cnt_next == CNT_FULL)
                r_det_f <= i_raw;
        end
    end

    assign o_det_f = r_det_f;

endmodule

// File: rtl/auto_nav_ctrl.sv
// Autonomous wall-following drive FSM with tick-based dwell timing and U-turn beacon pulses.
module auto_nav_ctrl
    import auto_nav_pkg::*;
#(
    parameter int CLK_DIV     = 2000000,
    parameter int WAIT_TICKS  = 100,
    parameter int TURN_TICKS  = 100,
    parameter int UTURN_TICKS = 200,
    parameter int COOL_TICKS  = 50,
    parameter int DEB_LEN     = 16
) (
    input  logic       i_sys_clk,
    input  logic       i_rst,
    input  logic       i_enable,
    input  logic       i_hand,
    input  logic [3:0] i_detector,
    output logic [1:0] o_state,
    output logic [3:0] o_moving_state,
    output logic       o_pl_beacon_sig,
    output logic       o_de_beacon_sig,
    output logic [7:0] o_turn_count
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int M1 = (WAIT_TICKS > TURN_TICKS) ? WAIT_TICKS : TURN_TICKS;
    localparam int M2 = (UTURN_TICKS > COOL_TICKS) ? UTURN_TICKS : COOL_TICKS;
    localparam int DMAX = (M1 > M2) ? M1 : M2;
    localparam int DW = $clog2(DMAX + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [DW-1:0] L_DMAX  = DW'(DMAX);
    localparam logic [DW-1:0] L_WAIT  = DW'(WAIT_TICKS);
    localparam logic [DW-1:0] L_TURN  = DW'(TURN_TICKS);
    localparam logic [DW-1:0] L_UTURN = DW'(UTURN_TICKS);
    localparam logic [DW-1:0] L_COOL  = DW'(COOL_TICKS);

    logic [1:0]    r_state;
    logic [3:0]    r_moving;
    logic [3:0]    r_dir;
    logic          r_uturn;
    logic          r_pl;
    logic          r_de;
    logic [7:0]    r_turn_count;
    logic [PW-1:0] r_presc;
    logic [DW-1:0] r_dwell;

    logic [3:0]    w_det_f;
    decision_t     w_dec;
    logic [1:0]    w_state_next;
    logic [3:0]    w_moving_next;
    logic [3:0]    w_dir_next;
    logic          w_uturn_next;
    logic          w_pl_next;
    logic          w_de_next;
    logic          w_tick;
    logic          w_enter_turn;
    logic [DW-1:0] w_turn_lim;

    det_debounce #(.DEB_LEN(DEB_LEN)) u_debounce (
        .i_clk   (i_sys_clk),
        .i_rst   (i_rst),
        .i_raw   (i_detector),
        .o_det_f (w_det_f)
    );

    assign w_tick       = (r_presc == PRESC_LAST);
    assign w_turn_lim   = r_uturn ? L_UTURN : L_TURN;
    assign w_enter_turn = (w_state_next == ST_TURNING) && (r_state != ST_TURNING);

    always_comb begin
        w_dec        = nav_decide(w_det_f, i_hand);
        w_state_next = r_state;
        w_dir_next   = r_dir;
        w_uturn_next = r_uturn;
        w_pl_next    = 1'b0;
        w_de_next    = 1'b0;
        // Dropping enable overrides any timed exit and suppresses beacons.
        if (!i_enable) begin
            w_state_next = ST_WAITING;
        end else begin
            case (r_state)
                ST_WAITING: if (r_dwell >= L_WAIT) begin
                    case (w_dec)
                        DEC_FWD:   w_state_next = ST_COOLING;
                        DEC_LEFT:  begin w_state_next = ST_TURNING; w_dir_next = MV_LEFT;  w_uturn_next = 1'b0; end
                        DEC_RIGHT: begin w_state_next = ST_TURNING; w_dir_next = MV_RIGHT; w_uturn_next = 1'b0; end
                        default: begin
                            w_state_next = ST_TURNING;
                            w_dir_next   = i_hand ? MV_LEFT : MV_RIGHT;
                            w_uturn_next = 1'b1;
                            w_pl_next    = 1'b1;
                        end
                    endcase
                end
                ST_TURNING: if (r_dwell >= w_turn_lim) begin
                    w_state_next = ST_COOLING;
                    w_de_next    = r_uturn;
                end
                ST_COOLING: if (r_dwell >= L_COOL) w_state_next = ST_MOVING;
                default:    if (w_det_f[3] || !w_det_f[2] || !w_det_f[1]) w_state_next = ST_WAITING;
            endcase
        end
    end

    always_comb begin
        case (w_state_next)
            ST_WAITING: w_moving_next = MV_STOP;
            ST_TURNING: w_moving_next = w_dir_next;
            default:    w_moving_next = MV_FORWARD;
        endcase
    end

    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_WAITING;
            r_moving     <= MV_STOP;
            r_dir        <= MV_STOP;
            r_uturn      <= 1'b0;
            r_pl         <= 1'b0;
            r_de         <= 1'b0;
            r_turn_count <= '0;
            r_presc      <= '0;
            r_dwell      <= '0;
        end else begin
            r_state  <= w_state_next;
            r_moving <= w_moving_next;
            r_dir    <= w_dir_next;
            r_uturn  <= w_uturn_next;
            r_pl     <= w_pl_next;
            r_de     <= w_de_next;
            if ((w_state_next != r_state) || !i_enable) begin
                r_presc <= '0;
                r_dwell <= '0;
            end else if (w_tick) begin
                r_presc <= '0;
                if (r_dwell != L_DMAX)
                    r_dwell <= r_dwell + 1'b1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
            if (w_enter_turn && (r_turn_count != 8'hFF))
                r_turn_count <= r_turn_count + 1'b1;
        end
    end

    assign o_state         = r_state;
    assign o_moving_state  = r_moving;
    assign o_pl_beacon_sig = r_pl;
    assign o_de_beacon_sig = r_de;
    assign o_turn_count    = r_turn_count;

endmodule

// File: tb/tb_auto_nav_ctrl.sv
// Scoreboard bench: expected state/drive segments are queued with stimulus and matched against observed ones.
module tb_auto_nav_ctrl;

    localparam logic [1:0] S_W = 2'b00, S_M = 2'b01, S_T = 2'b10, S_C = 2'b11;
    localparam logic [3:0] D_STOP = 4'b0000, D_FWD = 4'b0001, D_L = 4'b0100, D_R = 4'b1000;

    typedef struct packed {
        logic [1:0]  st;
        logic [3:0]  mv;
        logic [15:0] len;
    } seg_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       hand = 1'b0;
    logic [3:0] detector = 4'b1111;
    logic [1:0] o_state;
    logic [3:0] o_moving_state;
    logic       o_pl_beacon_sig;
    logic       o_de_beacon_sig;
    logic [7:0] o_turn_count;

    seg_t exp_q[$];
    seg_t obs_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   mon_en = 1'b0;
    logic [1:0] mon_st = 2'b00;
    logic [3:0] mon_mv = 4'b0000;
    int   mon_run = 0;
    int   turn_entries = 0, pl_total = 0, pl_hits = 0, de_total = 0, de_hits = 0;

    auto_nav_ctrl #(
        .CLK_DIV(4), .WAIT_TICKS(3), .TURN_TICKS(2),
        .UTURN_TICKS(4), .COOL_TICKS(2), .DEB_LEN(3)
    ) dut (
        .i_sys_clk       (clk),
        .i_rst           (rst),
        .i_enable        (enable),
        .i_hand          (hand),
        .i_detector      (detector),
        .o_state         (o_state),
        .o_moving_state  (o_moving_state),
        .o_pl_beacon_sig (o_pl_beacon_sig),
        .o_de_beacon_sig (o_de_beacon_sig),
        .o_turn_count    (o_turn_count)
    );

    always #5 clk = ~clk;

    // Segment recorder: one entry per completed run of identical {state, moving_state}.
    always @(negedge clk) begin
        if (mon_en) begin
            seg_t s;
            if (o_pl_beacon_sig) begin
                pl_total++;
                if (o_state == S_T && mon_st != S_T) pl_hits++;
            end
            if (o_de_beacon_sig) begin
                de_total++;
                if (o_state == S_C && mon_st == S_T) de_hits++;
            end
            if (o_state == S_T && mon_st != S_T) turn_entries++;
            if (o_state == mon_st && o_moving_state == mon_mv) begin
                mon_run++;
            end else begin
                s.st = mon_st; s.mv = mon_mv; s.len = 16'(mon_run);
                obs_q.push_back(s);
                mon_st  = o_state;
                mon_mv  = o_moving_state;
                mon_run = 1;
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        if (obs !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic push_seg(input logic [1:0] st, input logic [3:0] mv, input int len);
        seg_t s;
        s.st = st; s.mv = mv; s.len = 16'(len);
        exp_q.push_back(s);
    endtask

    task automatic wait_state(input logic [1:0] st, input int budget, input string tag);
        int n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (o_state != st && n < budget);
        if (o_state != st) check_val({tag, "_timeout"}, {30'd0, o_state}, {30'd0, st});
    endtask

    task automatic drain(input string tag);
        seg_t e, o;
        int n = 0;
        while (obs_q.size() < exp_q.size() && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        check_val({tag, "_nseg"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            check_val({tag, "_st_mv"}, {26'd0, o.st, o.mv}, {26'd0, e.st, e.mv});
            if (e.len != 0) check_val({tag, "_len"}, {16'd0, o.len}, {16'd0, e.len});
            $display("seg %s: state=%b drive=%b cycles=%0d", tag, o.st, o.mv, o.len);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        // Reset state
        detector = 4'b0110; enable = 1'b1; hand = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_state", {30'd0, o_state}, 0);
        check_val("rst_drive", {28'd0, o_moving_state}, 0);
        check_val("rst_beacons", {30'd0, o_pl_beacon_sig, o_de_beacon_sig}, 0);
        check_val("rst_count", {24'd0, o_turn_count}, 0);
        @(posedge clk); #1;
        rst = 1'b0; mon_en = 1'b1;

        // Corridor
        push_seg(S_W, D_STOP, 13); push_seg(S_C, D_FWD, 9);
        wait_state(S_M, 60, "corr");
        repeat (20) @(negedge clk);
        #1;
        check_val("corr_hold_state", {30'd0, o_state}, {30'd0, S_M});
        check_val("corr_hold_drive", {28'd0, o_moving_state}, {28'd0, D_FWD});
        drain("corridor");

        // Right opening, hand=0
        detector = 4'b1100;
        push_seg(S_M, D_FWD, 0); push_seg(S_W, D_STOP, 13); push_seg(S_T, D_R, 9); push_seg(S_C, D_FWD, 9);
        wait_state(S_T, 60, "ropen"); detector = 4'b0110;
        wait_state(S_M, 60, "ropen_mv");
        drain("right_open");
        check_val("count_1", {24'd0, o_turn_count}, 1);

        // Left opening, hand=1
        hand = 1'b1; detector = 4'b1010;
        push_seg(S_M, D_FWD, 0); push_seg(S_W, D_STOP, 13); push_seg(S_T, D_L, 9); push_seg(S_C, D_FWD, 9);
        wait_state(S_T, 60, "lopen"); detector = 4'b0110;
        wait_state(S_M, 60, "lopen_mv");
        drain("left_open");
        check_val("count_2", {24'd0, o_turn_count}, 2);

        // Hand contrast with detector=0100
        hand = 1'b0; detector = 4'b0100;
        push_seg(S_M, D_FWD, 0); push_seg(S_W, D_STOP, 13); push_seg(S_T, D_R, 9); push_seg(S_C, D_FWD, 9);
        wait_state(S_T, 60, "hc0"); detector = 4'b0110;
        wait_state(S_M, 60, "hc0_mv");
        drain("hand0_0100");
        hand = 1'b1; detector = 4'b0100;
        push_seg(S_M, D_FWD, 0); push_seg(S_W, D_STOP, 13); push_seg(S_C, D_FWD, 9);
        wait_state(S_C, 60, "hc1"); detector = 4'b0110;
        wait_state(S_M, 60, "hc1_mv");
        drain("hand1_0100");
        check_val("count_3", {24'd0, o_turn_count}, 3);
        check_val("no_pl_on_plain_turns", pl_total, 0);

        // Dead ends, both hands
        hand = 1'b0; detector = 4'b1111;
        push_seg(S_M, D_FWD, 0); push_seg(S_W, D_STOP, 13); push_seg(S_T, D_R, 17); push_seg(S_C, D_FWD, 9);
        wait_state(S_T, 60, "dead0"); detector = 4'b0110;
        wait_state(S_M, 60, "dead0_mv");
        drain("dead_hand0");
        check_val("dead0_pl_total", pl_total, 1);
        check_val("dead0_pl_at_entry", pl_hits, 1);
        check_val("dead0_de_total", de_total, 1);
        check_val("dead0_de_at_exit", de_hits, 1);
        hand = 1'b1; detector = 4'b1111;
        push_seg(S_M, D_FWD, 0); push_seg(S_W, D_STOP, 13); push_seg(S_T, D_L, 17); push_seg(S_C, D_FWD, 9);
        wait_state(S_T, 60, "dead1"); detector = 4'b0110;
        wait_state(S_M, 60, "dead1_mv");
        drain("dead_hand1");
        check_val("dead1_pl_total", pl_total, 2);
        check_val("dead1_de_total", de_total, 2);
        check_val("count_5", {24'd0, o_turn_count}, 5);

        // Two-cycle glitch must not reach the FSM
        detector = 4'b0100;
        repeat (2) @(negedge clk);
        #1;
        detector = 4'b0110;
        repeat (15) @(negedge clk);
        #1;
        check_val("glitch_state", {30'd0, o_state}, {30'd0, S_M});
        check_val("glitch_no_seg", obs_q.size(), 0);

        // Enable drop during a turn
        hand = 1'b0; detector = 4'b1100;
        push_seg(S_M, D_FWD, 0); push_seg(S_W, D_STOP, 13); push_seg(S_T, D_R, 0);
        wait_state(S_T, 60, "abort");
        repeat (3) @(negedge clk);
        #1;
        enable = 1'b0;
        @(negedge clk); #1;
        check_val("abort_state", {30'd0, o_state}, {30'd0, S_W});
        check_val("abort_drive", {28'd0, o_moving_state}, {28'd0, D_STOP});
        drain("abort");
        repeat (5) @(negedge clk);
        #1;
        check_val("abort_no_de", de_total, 2);
        check_val("count_6", {24'd0, o_turn_count}, 6);

        // Saturation of turn_count
        detector = 4'b0100; hand = 1'b0; enable = 1'b1;
        begin
            int n = 0;
            while (turn_entries < 250 && n < 20000) begin @(negedge clk); #1; n++; end
            check_val("count_250", {24'd0, o_turn_count}, 250);
            while (turn_entries < 300 && n < 20000) begin @(negedge clk); #1; n++; end
            check_val("turns_reached_300", turn_entries, 300);
            check_val("count_sat_255", {24'd0, o_turn_count}, 255);
        end
        obs_q.delete();

        // Asynchronous reset mid-run
        @(negedge clk); #2;
        rst = 1'b1; mon_en = 1'b0;
        #1;
        check_val("arst_state", {30'd0, o_state}, 0);
        check_val("arst_drive", {28'd0, o_moving_state}, 0);
        check_val("arst_beacons", {30'd0, o_pl_beacon_sig, o_de_beacon_sig}, 0);
        check_val("arst_count", {24'd0, o_turn_count}, 0);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
